// File: rtl/regfile_pkg.sv
// ============================================================================
// Module : regfile_pkg
// Brief  : Shared sizing constants for the general-purpose register file.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int REG_DATA_W    = 32;
    localparam int REG_ADDR_W    = 5;
    localparam int REG_NUM_C     = 32;
    localparam int REG_ZERO_ADDR = 0;

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/regfile_rport.sv
// ============================================================================
// Module : regfile_rport
// Brief  : Combinational read-port priority mux with same-cycle write bypass.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_rport
    import regfile_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              rst,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rdata
);

    localparam logic [ADDR_W-1:0] C_ZERO_ADDR = ADDR_W'(REG_ZERO_ADDR);

    always_comb begin
        rdata = '0;
        if (rst) begin
            rdata = '0;
        end else if (raddr == C_ZERO_ADDR) begin
            // r0 reads zero even while a write to r0 is being presented
            rdata = '0;
        end else if (!re) begin
            rdata = '0;
        end else if (we && (waddr == raddr)) begin
            rdata = wdata;
        end else begin
            rdata = mem_rdata;
        end
    end

endmodule : regfile_rport

`default_nettype wire

// File: rtl/regfile.sv
// ============================================================================
// Module : regfile
// Brief  : 32x32 register file, two zero-latency read ports, one write port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W  = REG_DATA_W,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int REG_NUM = REG_NUM_C
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    localparam logic [ADDR_W-1:0] C_ZERO_ADDR = ADDR_W'(REG_ZERO_ADDR);

    logic [DATA_W-1:0] r_mem [REG_NUM];
    logic [DATA_W-1:0] w_mem_rd1;
    logic [DATA_W-1:0] w_mem_rd2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we && (waddr != C_ZERO_ADDR)) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign w_mem_rd1 = r_mem[raddr1];
    assign w_mem_rd2 = r_mem[raddr2];

    regfile_rport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rport1 (
        .rst       (rst),
        .re        (re1),
        .raddr     (raddr1),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .mem_rdata (w_mem_rd1),
        .rdata     (rdata1)
    );

    regfile_rport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rport2 (
        .rst       (rst),
        .re        (re2),
        .raddr     (raddr2),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .mem_rdata (w_mem_rd2),
        .rdata     (rdata2)
    );

endmodule : regfile

`default_nettype wire
